// File: rtl/game_io_adapter.sv
// ---------------------------------------------------------------------------
// game_io_adapter
//
// Pad-side adapter between the Caravel GPIO/LA signals and a game core.
// Sequences the core reset from the management SoC's gpio_ready flag and an
// external reset pad, drives the pad output enables for the design and debug
// outputs, and synchronises/debounces the active-low push buttons into
// active-high level and press-pulse outputs.
//
// Ports:
//   wb_clk_i           sole clock
//   wb_rst_i           asynchronous reset, active-high
//   gpio_ready         LA bit, GPIO configuration finished
//   ext_reset_n        async pad, active-low external reset
//   btn_n_in[N_BTN]    async pads, active-low buttons
//   btn_out[N_BTN]     debounced level, 1 = pressed
//   btn_press[N_BTN]   one-cycle pulse per accepted press
//   design_reset       reset to the game core, active-high
//   design_oeb[N_OUT]  pad OEB for design outputs (0 = drive)
//   debug_oeb[2]       pad OEB for the debug outputs
//   debug_design_reset copy of design_reset
//   debug_gpio_ready   registered gpio_ready
//
// Optional feature macro: GAME_IO_LA_OVERRIDE_EN
//   When defined, adds la_btn_val[N_BTN] / la_btn_sel[N_BTN]. A selected
//   channel takes its level from the registered la_btn_val bit instead of
//   the debouncer.
// ---------------------------------------------------------------------------
module game_io_adapter #(
  parameter int N_BTN           = 4,
  parameter int N_OUT           = 6,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int RST_HOLD        = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             gpio_ready,
  input  logic             ext_reset_n,
  input  logic [N_BTN-1:0] btn_n_in,
`ifdef GAME_IO_LA_OVERRIDE_EN
  input  logic [N_BTN-1:0] la_btn_val,
  input  logic [N_BTN-1:0] la_btn_sel,
`endif
  output logic [N_BTN-1:0] btn_out,
  output logic [N_BTN-1:0] btn_press,
  output logic             design_reset,
  output logic [N_OUT-1:0] design_oeb,
  output logic [1:0]       debug_oeb,
  output logic             debug_design_reset,
  output logic             debug_gpio_ready
);

  localparam int            CW        = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX   = CW'(DEBOUNCE_CYCLES - 1);
  localparam int            HW        = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(RST_HOLD - 1);

  typedef enum logic [1:0] {
    WAIT_READY = 2'd0,
    HOLD       = 2'd1,
    RUN        = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_nextState;
  logic [HW-1:0]          r_holdCnt;
  logic [HW-1:0]          w_nextHoldCnt;
  logic                   r_rdyQ;
  logic [SYNC_STAGES-1:0] r_extSync;
  logic                   w_extRstN;
  logic                   w_nextReset;
  logic                   w_nextOeb;
  logic                   r_designReset;
  logic [N_OUT-1:0]       r_designOeb;
  logic [1:0]             r_debugOeb;

  assign w_extRstN = r_extSync[SYNC_STAGES-1];

  // gpio_ready comes from the LA bank in the same clock domain, so one
  // register is enough; ext_reset_n is a raw pad and gets a full synchroniser.
  // Synchroniser flops reset to 1 so a reset never looks like a pad event.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_rdyQ    <= 1'b0;
      r_extSync <= '1;
    end else begin
      r_rdyQ    <= gpio_ready;
      r_extSync <= {r_extSync[SYNC_STAGES-2:0], ext_reset_n};
    end
  end

  // Reset sequencer next-state logic. Losing gpio_ready overrides
  // everything, including a pending external reset.
  always_comb begin
    w_nextState   = r_state;
    w_nextHoldCnt = r_holdCnt;
    case (r_state)
      WAIT_READY: begin
        if (r_rdyQ) begin
          w_nextState   = HOLD;
          w_nextHoldCnt = HOLD_LOAD;
        end
      end
      HOLD: begin
        if (!w_extRstN) begin
          w_nextHoldCnt = HOLD_LOAD;
        end else if (r_holdCnt == '0) begin
          w_nextState = RUN;
        end else begin
          w_nextHoldCnt = r_holdCnt - 1'b1;
        end
      end
      RUN: begin
        if (!w_extRstN) begin
          w_nextState   = HOLD;
          w_nextHoldCnt = HOLD_LOAD;
        end
      end
      default: begin
        w_nextState   = WAIT_READY;
        w_nextHoldCnt = '0;
      end
    endcase
    if (!r_rdyQ) begin
      w_nextState   = WAIT_READY;
      w_nextHoldCnt = '0;
    end
  end

  // Outputs decode the next state so they switch on the same edge as r_state.
  assign w_nextReset = (w_nextState != RUN);
  assign w_nextOeb   = (w_nextState == WAIT_READY);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state       <= WAIT_READY;
      r_holdCnt     <= '0;
      r_designReset <= 1'b1;
      r_designOeb   <= '1;
      r_debugOeb    <= 2'b11;
    end else begin
      r_state       <= w_nextState;
      r_holdCnt     <= w_nextHoldCnt;
      r_designReset <= w_nextReset;
      r_designOeb   <= {N_OUT{w_nextOeb}};
      r_debugOeb    <= {2{w_nextOeb}};
    end
  end

  assign design_reset       = r_designReset;
  assign debug_design_reset = r_designReset;
  assign design_oeb         = r_designOeb;
  assign debug_oeb          = r_debugOeb;
  assign debug_gpio_ready   = r_rdyQ;

  // One independent synchroniser + debouncer per button channel.
  for (genvar g = 0; g < N_BTN; g++) begin : g_btn
    logic [SYNC_STAGES-1:0] r_sync;
    logic [CW-1:0]          r_cnt;
    logic                   r_stable;
    logic                   r_press;
    logic                   w_s;
    logic                   w_stableNext;
    logic [CW-1:0]          w_cntNext;

    assign w_s = ~r_sync[SYNC_STAGES-1];

    // The counter measures consecutive cycles of disagreement with the
    // accepted level; any agreeing cycle drops it back to zero. It saturates
    // by construction because reaching CNT_MAX always accepts and clears.
    always_comb begin
      w_stableNext = r_stable;
      w_cntNext    = '0;
      if (w_s != r_stable) begin
        if (r_cnt == CNT_MAX) begin
          w_stableNext = w_s;
        end else begin
          w_cntNext = r_cnt + 1'b1;
        end
      end
`ifdef GAME_IO_LA_OVERRIDE_EN
      if (la_btn_sel[g]) begin
        w_stableNext = la_btn_val[g];
        w_cntNext    = '0;
      end
`endif
    end

    // Press pulses are suppressed whenever the core is held in reset, so a
    // button already held when the core comes out of reset never pulses.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
        r_sync   <= '1;
        r_cnt    <= '0;
        r_stable <= 1'b0;
        r_press  <= 1'b0;
      end else begin
        r_sync   <= {r_sync[SYNC_STAGES-2:0], btn_n_in[g]};
        r_cnt    <= w_cntNext;
        r_stable <= w_stableNext;
        r_press  <= w_stableNext & ~r_stable & ~w_nextReset;
      end
    end

    assign btn_out[g]   = r_stable;
    assign btn_press[g] = r_press;
  end

endmodule

// File: tb/tb_game_io_adapter.sv
// ---------------------------------------------------------------------------
// tb_game_io_adapter
//
// Self-checking bench for game_io_adapter. A behavioural model tracks the
// expected outputs from the block's timing rules: the core runs once
// gpio_ready has been seen for RST_HOLD+1 consecutive edges and the synced
// external reset has been high for RST_HOLD consecutive edges; a button level
// flips once the last DEBOUNCE_CYCLES synced samples all disagree with it.
// ---------------------------------------------------------------------------
module tb_game_io_adapter;

  localparam int N_BTN = 4;
  localparam int N_OUT = 6;
  localparam int SYNC  = 2;
  localparam int DB    = 4;
  localparam int RST_HOLD = 8;
  localparam int VW = 2 + N_OUT + 2 + 1 + 2 * N_BTN;
  localparam logic [VW-1:0] RST_VEC =
    {1'b1, 1'b1, {N_OUT{1'b1}}, 2'b11, 1'b0, {N_BTN{1'b0}}, {N_BTN{1'b0}}};

  logic             clk;
  logic             rst;
  logic             gpioReady;
  logic             extResetN;
  logic [N_BTN-1:0] btnNIn;
`ifdef GAME_IO_LA_OVERRIDE_EN
  logic [N_BTN-1:0] laVal;
  logic [N_BTN-1:0] laSel;
`endif
  logic [N_BTN-1:0] btnOut;
  logic [N_BTN-1:0] btnPress;
  logic             designReset;
  logic [N_OUT-1:0] designOeb;
  logic [1:0]       debugOeb;
  logic             debugDesignReset;
  logic             debugGpioReady;
  logic [VW-1:0]    obsVec;

  int vectors;
  int miscompares;

  // Model state
  bit               mRdyQ;
  bit               mExt1, mExt2;
  int               runR, runE;
  bit [N_BTN-1:0]   mPad1, mPad2;
  bit [N_BTN-1:0]   mOut;
  bit               mHist [N_BTN][DB];
  bit               expReset, expOeb, expRdy;
  bit [N_BTN-1:0]   expPress;

  game_io_adapter #(
    .N_BTN(N_BTN), .N_OUT(N_OUT), .SYNC_STAGES(SYNC),
    .DEBOUNCE_CYCLES(DB), .RST_HOLD(RST_HOLD)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .gpio_ready(gpioReady),
    .ext_reset_n(extResetN),
    .btn_n_in(btnNIn),
`ifdef GAME_IO_LA_OVERRIDE_EN
    .la_btn_val(laVal),
    .la_btn_sel(laSel),
`endif
    .btn_out(btnOut),
    .btn_press(btnPress),
    .design_reset(designReset),
    .design_oeb(designOeb),
    .debug_oeb(debugOeb),
    .debug_design_reset(debugDesignReset),
    .debug_gpio_ready(debugGpioReady)
  );

  assign obsVec = {designReset, debugDesignReset, designOeb, debugOeb,
                   debugGpioReady, btnOut, btnPress};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [VW-1:0] expVec();
    return {expReset, expReset, {N_OUT{expOeb}}, {2{expOeb}}, expRdy, mOut, expPress};
  endfunction

  // Model back to its post-reset state.
  task automatic modelReset();
    mRdyQ = 1'b0;
    mExt1 = 1'b1;
    mExt2 = 1'b1;
    runR = 0;
    runE = 0;
    mPad1 = '1;
    mPad2 = '1;
    mOut = '0;
    for (int i = 0; i < N_BTN; i++)
      for (int k = 0; k < DB; k++) mHist[i][k] = 1'b0;
    expReset = 1'b1;
    expOeb = 1'b1;
    expRdy = 1'b0;
    expPress = '0;
  endtask

  // Advance the model by one clock edge using the inputs seen at that edge.
  task automatic modelEdge();
    bit r, e, allDiff;
    bit [N_BTN-1:0] s, newOut;
    r = mRdyQ;
    e = mExt2;
    runR = r ? runR + 1 : 0;
    runE = e ? runE + 1 : 0;
    expReset = !((runR >= RST_HOLD + 1) && (runE >= RST_HOLD));
    expOeb = !r;
    mRdyQ = gpioReady;
    expRdy = gpioReady;
    mExt2 = mExt1;
    mExt1 = extResetN;
    s = ~mPad2;
    newOut = mOut;
    for (int i = 0; i < N_BTN; i++) begin
      for (int k = 0; k < DB - 1; k++) mHist[i][k] = mHist[i][k+1];
      mHist[i][DB-1] = s[i];
      allDiff = 1'b1;
      for (int k = 0; k < DB; k++)
        if (mHist[i][k] == mOut[i]) allDiff = 1'b0;
      if (allDiff) newOut[i] = s[i];
`ifdef GAME_IO_LA_OVERRIDE_EN
      if (laSel[i]) begin
        newOut[i] = laVal[i];
        for (int k = 0; k < DB; k++) mHist[i][k] = laVal[i];
      end
`endif
    end
    expPress = newOut & ~mOut & {N_BTN{~expReset}};
    mOut = newOut;
    mPad2 = mPad1;
    mPad1 = btnNIn;
  endtask

  // One clock: model follows the edge, outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (obsVec !== RST_VEC) begin
      miscompares++;
      $display("[TB] FAIL reset_hold: got %h expected %h", obsVec, RST_VEC);
    end
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    for (int c = 1; c <= 20; c++) begin
      tick();
      vectors++;
      if (obsVec !== expVec()) begin
        miscompares++;
        $display("[TB] FAIL wait_ready cycle %0d: got %h expected %h", c, obsVec, expVec());
      end
      vectors++;
      if ({designReset, designOeb, debugOeb} !== {1'b1, 6'h3F, 2'b11}) begin
        miscompares++;
        $display("[TB] FAIL wait_ready_oeb cycle %0d: got %b/%h/%b expected 1/3f/11",
                 c, designReset, designOeb, debugOeb);
      end
    end
  endtask

  task automatic test_ready_sequence();
    int oebEdge, fallEdge;
    oebEdge = 0;
    fallEdge = 0;
    gpioReady = 1'b1;
    for (int e = 1; e <= 30 && fallEdge == 0; e++) begin
      tick();
      vectors++;
      if (obsVec !== expVec()) begin
        miscompares++;
        $display("[TB] FAIL ready_seq cycle %0d: got %h expected %h", e, obsVec, expVec());
      end
      if (oebEdge == 0 && designOeb == '0) oebEdge = e;
      if (designReset == 1'b0) fallEdge = e;
    end
    // Edge 1 captures gpio_ready; OEBs drop one edge later, reset RST_HOLD after that.
    vectors++;
    if (oebEdge !== 2) begin
      miscompares++;
      $display("[TB] FAIL ready_oeb_edge: got %0d expected 2", oebEdge);
    end
    vectors++;
    if (fallEdge !== RST_HOLD + 2) begin
      miscompares++;
      $display("[TB] FAIL ready_fall_edge: got %0d expected %0d", fallEdge, RST_HOLD + 2);
    end
  endtask

  task automatic test_ext_reset();
    int riseEdge, fallEdge;
    riseEdge = 0;
    fallEdge = 0;
    extResetN = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      tick();
      extResetN = 1'b1;
      vectors++;
      if (obsVec !== expVec()) begin
        miscompares++;
        $display("[TB] FAIL ext_reset cycle %0d: got %h expected %h", e, obsVec, expVec());
      end
      if (riseEdge == 0 && designReset == 1'b1) riseEdge = e;
      if (riseEdge != 0 && fallEdge == 0 && designReset == 1'b0) fallEdge = e;
    end
    vectors++;
    if (riseEdge !== 3) begin
      miscompares++;
      $display("[TB] FAIL ext_rise_edge: got %0d expected 3", riseEdge);
    end
    vectors++;
    if (fallEdge !== 3 + RST_HOLD) begin
      miscompares++;
      $display("[TB] FAIL ext_fall_edge: got %0d expected %0d", fallEdge, 3 + RST_HOLD);
    end
    gpioReady = 1'b0;
    for (int e = 1; e <= 2; e++) begin
      tick();
      vectors++;
      if (obsVec !== expVec()) begin
        miscompares++;
        $display("[TB] FAIL ready_drop cycle %0d: got %h expected %h", e, obsVec, expVec());
      end
    end
    vectors++;
    if ({designOeb, debugOeb, designReset} !== {6'h3F, 2'b11, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL ready_drop_oeb: got %h/%b/%b expected 3f/11/1",
               designOeb, debugOeb, designReset);
    end
    gpioReady = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      tick();
      vectors++;
      if (obsVec !== expVec()) begin
        miscompares++;
        $display("[TB] FAIL ready_again cycle %0d: got %h expected %h", e, obsVec, expVec());
      end
    end
  endtask

  task automatic test_debounce();
    int riseEdge, presses, glitchHigh;
    riseEdge = 0;
    presses = 0;
    glitchHigh = 0;
    btnNIn[2] = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      tick();
      vectors++;
      if (obsVec !== expVec()) begin
        miscompares++;
        $display("[TB] FAIL debounce_hold cycle %0d: got %h expected %h", e, obsVec, expVec());
      end
      if (riseEdge == 0 && btnOut[2]) riseEdge = e;
      if (btnPress[2]) presses++;
    end
    vectors++;
    if (riseEdge !== SYNC + DB) begin
      miscompares++;
      $display("[TB] FAIL debounce_rise_edge: got %0d expected %0d", riseEdge, SYNC + DB);
    end
    vectors++;
    if (presses !== 1) begin
      miscompares++;
      $display("[TB] FAIL debounce_press_count: got %0d expected 1", presses);
    end
    btnNIn[2] = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      vectors++;
      if (obsVec !== expVec()) begin
        miscompares++;
        $display("[TB] FAIL debounce_release cycle %0d: got %h expected %h", e, obsVec, expVec());
      end
    end
    btnNIn[0] = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (e == 3) btnNIn[0] = 1'b1;
      vectors++;
      if (obsVec !== expVec()) begin
        miscompares++;
        $display("[TB] FAIL glitch cycle %0d: got %h expected %h", e, obsVec, expVec());
      end
      if (btnOut[0]) glitchHigh++;
    end
    vectors++;
    if (glitchHigh !== 0) begin
      miscompares++;
      $display("[TB] FAIL glitch_rejected: got %0d high cycles expected 0", glitchHigh);
    end
  endtask

  task automatic test_hold_press();
    int sawInHold, presses;
    sawInHold = 0;
    presses = 0;
    gpioReady = 1'b0;
    repeat (3) tick();
    gpioReady = 1'b1;
    btnNIn[1] = 1'b0;
    for (int e = 1; e <= 16; e++) begin
      tick();
      vectors++;
      if (obsVec !== expVec()) begin
        miscompares++;
        $display("[TB] FAIL hold_press cycle %0d: got %h expected %h", e, obsVec, expVec());
      end
      if (btnOut[1] && designReset) sawInHold = 1;
      if (btnPress[1]) presses++;
    end
    vectors++;
    if (sawInHold !== 1 || presses !== 0) begin
      miscompares++;
      $display("[TB] FAIL hold_press_gate: got seen=%0d presses=%0d expected seen=1 presses=0",
               sawInHold, presses);
    end
    #3;
    rst = 1'b1;
    #1;
    vectors++;
    if (obsVec !== RST_VEC) begin
      miscompares++;
      $display("[TB] FAIL async_reset: got %h expected %h", obsVec, RST_VEC);
    end
    modelReset();
    #1;
    rst = 1'b0;
    btnNIn = '1;
  endtask

  task automatic test_random();
    for (int c = 1; c <= 600; c++) begin
      tick();
      vectors++;
      if (obsVec !== expVec()) begin
        miscompares++;
        $display("[TB] FAIL random cycle %0d: got %h expected %h", c, obsVec, expVec());
      end
      if (gpioReady) begin
        if ($urandom_range(0, 99) < 2) gpioReady = 1'b0;
      end else begin
        if ($urandom_range(0, 99) < 30) gpioReady = 1'b1;
      end
      extResetN = ($urandom_range(0, 99) < 4) ? 1'b0 : 1'b1;
      for (int i = 0; i < N_BTN; i++)
        if ($urandom_range(0, 5) == 0) btnNIn[i] = ~btnNIn[i];
    end
  endtask

`ifdef GAME_IO_LA_OVERRIDE_EN
  task automatic test_override();
    int presses;
    presses = 0;
    gpioReady = 1'b1;
    extResetN = 1'b1;
    btnNIn = '1;
    for (int e = 1; e <= 20; e++) begin
      tick();
      vectors++;
      if (obsVec !== expVec()) begin
        miscompares++;
        $display("[TB] FAIL override_settle cycle %0d: got %h expected %h", e, obsVec, expVec());
      end
    end
    laSel = 4'b1000;
    laVal = 4'b0000;
    btnNIn[3] = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      vectors++;
      if (obsVec !== expVec()) begin
        miscompares++;
        $display("[TB] FAIL override_pad_ignored cycle %0d: got %h expected %h", e, obsVec, expVec());
      end
    end
    laVal[3] = 1'b1;
    tick();
    vectors++;
    if ({btnOut[3], btnPress[3]} !== 2'b11) begin
      miscompares++;
      $display("[TB] FAIL override_rise: got out=%b press=%b expected 1/1", btnOut[3], btnPress[3]);
    end
    for (int e = 1; e <= 6; e++) begin
      tick();
      vectors++;
      if (obsVec !== expVec()) begin
        miscompares++;
        $display("[TB] FAIL override_hold cycle %0d: got %h expected %h", e, obsVec, expVec());
      end
      if (btnPress[3]) presses++;
    end
    vectors++;
    if (presses !== 0) begin
      miscompares++;
      $display("[TB] FAIL override_single_pulse: got %0d extra expected 0", presses);
    end
    laSel = 4'b0000;
    btnNIn[3] = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      tick();
      vectors++;
      if (obsVec !== expVec()) begin
        miscompares++;
        $display("[TB] FAIL override_handback cycle %0d: got %h expected %h", e, obsVec, expVec());
      end
    end
  endtask
`endif

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    gpioReady = 1'b0;
    extResetN = 1'b1;
    btnNIn = '1;
`ifdef GAME_IO_LA_OVERRIDE_EN
    laVal = '0;
    laSel = '0;
`endif
    modelReset();
    $display("[TB] starting game_io_adapter checks");
    test_reset();
    test_ready_sequence();
    test_ext_reset();
    test_debounce();
    test_hold_press();
    test_random();
`ifdef GAME_IO_LA_OVERRIDE_EN
    test_override();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
